// File: rtl/ps2_scan_decoder_fifo.sv
// ps2_scan_decoder_fifo: PS/2 set-2 scan-code decoder feeding a show-ahead ASCII FIFO
module ps2_scan_decoder_fifo #(
  parameter int ADDR_W   = 2,
  parameter bit SHIFT_EN = 1'b1,
  parameter bit ARROW_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_code,
  input  logic       rd_en,
  output logic [7:0] ascii_code,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       shift_active
);
  localparam logic [1:0] S_MAKE = 2'd0, S_BREAK = 2'd1, S_EXT = 2'd2, S_EXT_BREAK = 2'd3;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  logic [1:0] state, state_nx;
  logic shift_l, shift_r;
  logic [7:0] base, arrow, key, wdata;
  logic wr, do_wr, do_rd;
  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] count;
  always_comb begin
    base = 8'h00;
    case (scan_code)
      8'h1c: base = 8'h41;  8'h32: base = 8'h42;  8'h21: base = 8'h43;  8'h23: base = 8'h44;
      8'h24: base = 8'h45;  8'h2b: base = 8'h46;  8'h34: base = 8'h47;  8'h33: base = 8'h48;
      8'h43: base = 8'h49;  8'h3b: base = 8'h4a;  8'h42: base = 8'h4b;  8'h4b: base = 8'h4c;
      8'h3a: base = 8'h4d;  8'h31: base = 8'h4e;  8'h44: base = 8'h4f;  8'h4d: base = 8'h50;
      8'h15: base = 8'h51;  8'h2d: base = 8'h52;  8'h1b: base = 8'h53;  8'h2c: base = 8'h54;
      8'h3c: base = 8'h55;  8'h2a: base = 8'h56;  8'h1d: base = 8'h57;  8'h22: base = 8'h58;
      8'h35: base = 8'h59;  8'h1a: base = 8'h5a;
      8'h45: base = 8'h30;  8'h16: base = 8'h31;  8'h1e: base = 8'h32;  8'h26: base = 8'h33;
      8'h25: base = 8'h34;  8'h2e: base = 8'h35;  8'h36: base = 8'h36;  8'h3d: base = 8'h37;
      8'h3e: base = 8'h38;  8'h46: base = 8'h39;
      8'h5a: base = 8'h0d;  8'h29: base = 8'h20;  8'h66: base = 8'h08;
      default: base = 8'h00;
    endcase
  end
  assign arrow = !ARROW_EN ? 8'h00 : scan_code == 8'h75 ? 8'h11 : scan_code == 8'h72 ? 8'h12 :
                 scan_code == 8'h6b ? 8'h13 : scan_code == 8'h74 ? 8'h14 : 8'h00;
  assign key = (SHIFT_EN && !shift_active && base >= 8'h41 && base <= 8'h5a) ? base + 8'h20 : base;
  assign wdata = state == S_EXT ? arrow : key;
  assign wr = scan_done_tick && (state == S_MAKE ? base != 8'h00 : state == S_EXT && arrow != 8'h00);
  // E0/F0 always (re)start a prefix; only F0 right after E0 forms an extended break
  assign state_nx = scan_code == 8'he0 ? S_EXT :
                    scan_code == 8'hf0 ? (state == S_EXT ? S_EXT_BREAK : S_BREAK) : S_MAKE;
  assign shift_active = shift_l | shift_r;
  assign empty = count == '0;
  assign full = count == DEPTH;
  assign ascii_code = empty ? 8'h00 : mem[rd_ptr];
  assign do_wr = wr && (!full || rd_en);
  assign do_rd = rd_en && !empty;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_MAKE;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
    end else if (scan_done_tick) begin
      state <= state_nx;
      if (scan_code == 8'h12 && (state == S_MAKE || state == S_BREAK)) shift_l <= state == S_MAKE;
      if (scan_code == 8'h59 && (state == S_MAKE || state == S_BREAK)) shift_r <= state == S_MAKE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count + {{ADDR_W{1'b0}}, do_wr} - {{ADDR_W{1'b0}}, do_rd};
      if (wr && full && !rd_en) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) if (do_wr) mem[wr_ptr] <= wdata;
endmodule

// File: tb/tb_ps2_scan_decoder_fifo.sv
// tb_ps2_scan_decoder_fifo: scoreboard bench driving a shift/arrow-enabled and a plain decoder side by side
module tb_ps2_scan_decoder_fifo;
  logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0, rd = 1'b0;
  logic [7:0] code = 8'h00;
  logic [7:0] ascii [2];
  logic empty [2], full [2], ovf [2], shact [2];
  int tests = 0, fails = 0;
  logic [7:0] q [2][$];
  bit ovf_m [2];
  bit sl, sr, brk, ext;
  logic [7:0] letters [26] = '{8'h1c, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2b, 8'h34, 8'h33, 8'h43,
                               8'h3b, 8'h42, 8'h4b, 8'h3a, 8'h31, 8'h44, 8'h4d, 8'h15, 8'h2d,
                               8'h1b, 8'h2c, 8'h3c, 8'h2a, 8'h1d, 8'h22, 8'h35, 8'h1a};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1e, 8'h26, 8'h25, 8'h2e, 8'h36, 8'h3d, 8'h3e, 8'h46};
  logic [7:0] pool [17] = '{8'hf0, 8'he0, 8'h12, 8'h59, 8'h1c, 8'h32, 8'h45, 8'h16, 8'h5a,
                            8'h29, 8'h66, 8'h75, 8'h72, 8'h6b, 8'h74, 8'h0e, 8'h76};
  ps2_scan_decoder_fifo #(.ADDR_W(2), .SHIFT_EN(1'b1), .ARROW_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .scan_done_tick(tick), .scan_code(code), .rd_en(rd),
    .ascii_code(ascii[0]), .empty(empty[0]), .full(full[0]), .overflow(ovf[0]), .shift_active(shact[0]));
  ps2_scan_decoder_fifo #(.ADDR_W(2), .SHIFT_EN(1'b0), .ARROW_EN(1'b0)) dut_plain (
    .clk(clk), .reset_n(reset_n), .scan_done_tick(tick), .scan_code(code), .rd_en(rd),
    .ascii_code(ascii[1]), .empty(empty[1]), .full(full[1]), .overflow(ovf[1]), .shift_active(shact[1]));
  always #5 clk = ~clk;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] decode(int i, logic [7:0] c);
    for (int k = 0; k < 26; k++)
      if (letters[k] == c) return 8'(65 + k) + ((i == 0 && !(sl || sr)) ? 8'h20 : 8'h00);
    for (int k = 0; k < 10; k++) if (digits[k] == c) return 8'(48 + k);
    return c == 8'h5a ? 8'h0d : c == 8'h29 ? 8'h20 : c == 8'h66 ? 8'h08 : 8'h00;
  endfunction
  function automatic logic [7:0] arrow(int i, logic [7:0] c);
    if (i != 0) return 8'h00;
    return c == 8'h75 ? 8'h11 : c == 8'h72 ? 8'h12 : c == 8'h6b ? 8'h13 : c == 8'h74 ? 8'h14 : 8'h00;
  endfunction
  task automatic model_byte(logic [7:0] c, bit r);
    logic [7:0] v [2];
    v[0] = 8'h00;
    v[1] = 8'h00;
    if (c == 8'he0) begin
      ext = 1; brk = 0;
    end else if (c == 8'hf0) begin
      ext = ext && !brk; brk = 1;
    end else begin
      if (!ext && !brk) begin
        if (c == 8'h12) sl = 1;
        else if (c == 8'h59) sr = 1;
        else for (int i = 0; i < 2; i++) v[i] = decode(i, c);
      end else if (brk && !ext) begin
        if (c == 8'h12) sl = 0;
        if (c == 8'h59) sr = 0;
      end else if (ext && !brk) for (int i = 0; i < 2; i++) v[i] = arrow(i, c);
      ext = 0; brk = 0;
    end
    for (int i = 0; i < 2; i++)
      if (v[i] != 8'h00) begin
        if (q[i].size() == 4 && !r) ovf_m[i] = 1;
        else q[i].push_back(v[i]);
      end
  endtask
  task automatic status;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("empty%0d", i), empty[i], q[i].size() == 0);
      check($sformatf("full%0d", i), full[i], q[i].size() == 4);
      check($sformatf("overflow%0d", i), ovf[i], ovf_m[i]);
      check($sformatf("shift%0d", i), shact[i], sl || sr);
      if (q[i].size() == 0) check($sformatf("empty_code%0d", i), ascii[i], 8'h00);
    end
  endtask
  task automatic step(bit t, logic [7:0] c, bit r);
    status();
    tick = t; code = c; rd = r;
    if (t) model_byte(c, r);
    @(posedge clk); #2;
    tick = 0; rd = 0;
  endtask
  task automatic do_reset;
    reset_n = 0; tick = 0; rd = 0;
    @(posedge clk); #2;
    reset_n = 1;
    for (int i = 0; i < 2; i++) begin q[i].delete(); ovf_m[i] = 0; end
    sl = 0; sr = 0; brk = 0; ext = 0;
  endtask
  task automatic drain;
    for (int k = 0; k < 5; k++) step(0, 8'h00, 1);
    step(0, 8'h00, 0);
  endtask
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (reset_n && rd && !empty[i]) begin
        if (q[i].size() == 0) begin
          tests++; fails++;
          $display("FAIL pop%0d: got %0h expected no entry", i, ascii[i]);
        end else check($sformatf("head%0d", i), ascii[i], q[i].pop_front());
      end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    @(posedge clk); #2;
    do_reset();
    status();
    step(1, 8'h1c, 0); step(1, 8'hf0, 0); step(1, 8'h1c, 0);
    check("first_a", ascii[0], 8'h61);
    drain();
    foreach (pool[k]) if (k == 2 || k == 4 || k == 0) step(1, pool[k], 0);
    step(1, 8'h12, 0); step(1, 8'h1c, 0);
    check("shift_held", shact[0], 1'b1);
    drain();
    step(1, 8'he0, 0); step(1, 8'h75, 0); step(1, 8'he0, 0); step(1, 8'hf0, 0);
    step(1, 8'h75, 0); step(1, 8'he0, 0); step(1, 8'h6b, 0);
    check("arrow_up", ascii[0], 8'h11);
    check("arrow_off", empty[1], 1'b1);
    drain();
    do_reset();
    foreach (digits[k]) if (k >= 1 && k <= 5) step(1, digits[k], 0);
    check("full_flag", full[0], 1'b1);
    check("ovf_flag", ovf[0], 1'b1);
    check("full_head", ascii[0], 8'h31);
    step(1, 8'h46, 1);
    check("rw_head", ascii[0], 8'h32);
    check("rw_full", full[0], 1'b1);
    check("rw_ovf", ovf[0], 1'b1);
    drain();
    do_reset();
    step(1, 8'h0e, 0); step(1, 8'hf0, 0); step(1, 8'h76, 0); step(1, 8'h29, 0);
    check("space", ascii[0], 8'h20);
    drain();
    step(1, 8'h12, 0); step(1, 8'hf0, 0);
    do_reset();
    step(1, 8'h1c, 0);
    check("post_reset_a", ascii[0], 8'h61);
    drain();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(199) == 0) do_reset();
      else step($urandom_range(3) != 0,
                ($urandom_range(9) == 0) ? 8'($urandom) : pool[$urandom_range(16)],
                $urandom_range(2) == 0);
    end
    drain();
    status();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
